// File: rtl/demux1x2_4bits.sv
`default_nettype none
// ============================================================================
// Module      : demux1x2_4bits
// Description : 1:2 word demultiplexer. Splits one valid-qualified word stream
//               into two lanes, alternating lane 0 / lane 1 on every accepted
//               word. Each lane has a small show-ahead FIFO with a pop
//               handshake so the two consumers drain independently.
// Ports       : clk         - system clock, all state on rising edge
//               reset_L     - asynchronous active-low reset
//               data_in     - input word (BW bits)
//               valid_in    - data_in valid this cycle
//               ready_in    - block accepts a word this cycle (from state only)
//               sel_next    - lane that receives the next accepted word
//               data_out0/1 - head word of lane 0/1 FIFO (0 while empty)
//               valid_out0/1- lane 0/1 FIFO not empty
//               pop0/1      - lane 0/1 consumer takes the head word
// Revision    : 1.0 - initial release
// ============================================================================
module demux1x2_4bits #(
  parameter int BW    = 4,
  parameter int DEPTH = 2   // power of 2, >= 2
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic [BW-1:0] data_in,
  input  logic          valid_in,
  output logic          ready_in,
  output logic          sel_next,
  output logic [BW-1:0] data_out0,
  output logic          valid_out0,
  input  logic          pop0,
  output logic [BW-1:0] data_out1,
  output logic          valid_out1,
  input  logic          pop1
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic          r_sel_next;
  logic          w_accept;
  logic [1:0]    w_full;
  logic [1:0]    w_valid;
  logic [1:0]    w_pop_req;
  logic [BW-1:0] w_head [2];

  assign w_pop_req = {pop1, pop0};

  // Backpressure comes only from the lane that would take the next word, so
  // ready_in never depends on valid_in. A pop on a full lane does not open
  // the slot until the following cycle.
  assign ready_in = ~w_full[r_sel_next];
  assign w_accept = valid_in & ready_in;
  assign sel_next = r_sel_next;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_sel_next <= 1'b0;
    end else if (w_accept) begin
      r_sel_next <= ~r_sel_next;
    end
  end

  generate
    for (genvar g = 0; g < 2; g++) begin : g_lane
      logic [BW-1:0]      r_mem [DEPTH];
      logic [c_ptr_w-1:0] r_wr_ptr;
      logic [c_ptr_w-1:0] r_rd_ptr;
      logic [c_cnt_w-1:0] r_count;
      logic               w_push;
      logic               w_pop;
      logic               w_empty;

      assign w_empty   = (r_count == '0);
      assign w_full[g] = (r_count == c_cnt_w'(DEPTH));
      assign w_valid[g] = ~w_empty;
      assign w_push    = w_accept & (r_sel_next == 1'(g));
      // Pops on an empty lane are dropped so pointers and count stay put.
      assign w_pop     = w_pop_req[g] & ~w_empty;
      // Stale entries stay in memory after a pop; mask the head while empty.
      assign w_head[g] = w_empty ? '0 : r_mem[r_rd_ptr];

      always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
          end
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
            r_wr_ptr        <= r_wr_ptr + 1'b1;  // wraps modulo DEPTH
          end
          if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
          end
          if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
          end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
          end
        end
      end
    end
  endgenerate

  assign data_out0  = w_head[0];
  assign valid_out0 = w_valid[0];
  assign data_out1  = w_head[1];
  assign valid_out1 = w_valid[1];

endmodule
`default_nettype wire

// File: tb/tb_demux1x2_4bits.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux1x2_4bits
// Description : Self-checking bench for demux1x2_4bits (BW=4, DEPTH=2).
//               Directed vector table with hand-computed expected outputs,
//               plus hand-written reset and asynchronous-reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux1x2_4bits;

  logic       clk;
  logic       reset_L;
  logic [3:0] data_in;
  logic       valid_in;
  logic       ready_in;
  logic       sel_next;
  logic [3:0] data_out0;
  logic       valid_out0;
  logic       pop0;
  logic [3:0] data_out1;
  logic       valid_out1;
  logic       pop1;

  int n_checks = 0;
  int n_fail   = 0;

  demux1x2_4bits #(.BW(4), .DEPTH(2)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .sel_next   (sel_next),
    .data_out0  (data_out0),
    .valid_out0 (valid_out0),
    .pop0       (pop0),
    .data_out1  (data_out1),
    .valid_out1 (valid_out1),
    .pop1       (pop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       valid;
    logic [3:0] data;
    logic       p0;
    logic       p1;
    logic       e_rdy;
    logic       e_sel;
    logic       e_v0;
    logic [3:0] e_d0;
    logic       e_v1;
    logic [3:0] e_d1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic rs, logic v, logic [3:0] d,
                              logic a0, logic a1, logic rdy, logic sel,
                              logic v0, logic [3:0] d0, logic v1, logic [3:0] d1);
    vec_t t;
    t.name = nm; t.rst_n = rs; t.valid = v; t.data = d; t.p0 = a0; t.p1 = a1;
    t.e_rdy = rdy; t.e_sel = sel; t.e_v0 = v0; t.e_d0 = d0; t.e_v1 = v1; t.e_d1 = d1;
    return t;
  endfunction

  // Packed view of all outputs: {ready, sel, v0, d0, v1, d1}
  function automatic logic [12:0] outs();
    return {ready_in, sel_next, valid_out0, data_out0, valid_out1, data_out1};
  endfunction

  task automatic check(string nm, logic [12:0] act, logic [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {rdy,sel,v0,d0,v1,d1}=%b_%b_%b_%h_%b_%h required %b_%b_%b_%h_%b_%h",
               nm, act[12], act[11], act[10], act[9:6], act[5], act[4:1] , 1'b0,
               exp[12], exp[11], exp[10], exp[9:6], exp[5], exp[4:1]);
    end
  endtask

  initial begin
    // Test 2: fill both lanes with 1,2,3,0
    tbl.push_back(mk("fill_w1",  1,1,4'd1, 0,0, 1,1, 1,4'd1, 0,4'd0));
    tbl.push_back(mk("fill_w2",  1,1,4'd2, 0,0, 1,0, 1,4'd1, 1,4'd2));
    tbl.push_back(mk("fill_w3",  1,1,4'd3, 0,0, 1,1, 1,4'd1, 1,4'd2));
    tbl.push_back(mk("fill_w0",  1,1,4'd0, 0,0, 0,0, 1,4'd1, 1,4'd2));
    // Test 3: stalled word held, then pop0 frees lane 0
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk("stall_hold", 1,1,4'd5, 0,0, 0,0, 1,4'd1, 1,4'd2));
    tbl.push_back(mk("full_pop0",  1,1,4'd5, 1,0, 1,0, 1,4'd3, 1,4'd2));
    tbl.push_back(mk("accept_5",   1,1,4'd5, 0,0, 0,1, 1,4'd3, 1,4'd2));
    tbl.push_back(mk("drain_a",    1,0,4'd0, 1,1, 1,1, 1,4'd5, 1,4'd0));
    tbl.push_back(mk("drain_b",    1,0,4'd0, 1,1, 1,1, 0,4'd0, 0,4'd0));
    // Test 4: reset, then pop on empty lanes
    tbl.push_back(mk("reset_mid",  0,0,4'd0, 0,0, 1,0, 0,4'd0, 0,4'd0));
    tbl.push_back(mk("pop1_empty", 1,0,4'd0, 0,1, 1,0, 0,4'd0, 0,4'd0));
    tbl.push_back(mk("pop_both_e", 1,0,4'd0, 1,1, 1,0, 0,4'd0, 0,4'd0));
    tbl.push_back(mk("after_e_w6", 1,1,4'd6, 0,0, 1,1, 1,4'd6, 0,4'd0));
    tbl.push_back(mk("after_e_w7", 1,1,4'd7, 0,0, 1,0, 1,4'd6, 1,4'd7));
    tbl.push_back(mk("after_e_dr", 1,0,4'd0, 1,1, 1,0, 0,4'd0, 0,4'd0));
    // Test 5: continuous push 1..8 with both lanes popping every cycle.
    // Odd words land in lane 0, even in lane 1; each is popped one cycle later.
    for (int k = 1; k <= 8; k++) begin
      logic [3:0] w;
      w = 4'(k);
      if (k % 2 == 1)
        tbl.push_back(mk("stream", 1,1,w, 1,1, 1,1, 1,w, 0,4'd0));
      else
        tbl.push_back(mk("stream", 1,1,w, 1,1, 1,0, 0,4'd0, 1,w));
    end
    tbl.push_back(mk("stream_end", 1,0,4'd0, 1,1, 1,0, 0,4'd0, 0,4'd0));
  end

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 4'd0;
    pop0     = 1'b0;
    pop1     = 1'b0;

    // Test 1: reset held 2 cycles, then released
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("in_reset", outs(), {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0});
    reset_L = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_reset", outs(), {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0});

    // Table-driven vectors: inputs applied at negedge, outputs checked at the
    // following negedge (after one rising edge).
    foreach (tbl[i]) begin
      reset_L  = tbl[i].rst_n;
      valid_in = tbl[i].valid;
      data_in  = tbl[i].data;
      pop0     = tbl[i].p0;
      pop1     = tbl[i].p1;
      @(posedge clk);
      @(negedge clk);
      check(tbl[i].name, outs(),
            {tbl[i].e_rdy, tbl[i].e_sel, tbl[i].e_v0, tbl[i].e_d0,
             tbl[i].e_v1, tbl[i].e_d1});
    end

    // Test 6: fill both lanes, then assert reset between clock edges
    valid_in = 1'b1;
    pop0     = 1'b0;
    pop1     = 1'b0;
    for (int k = 11; k <= 14; k++) begin
      data_in = 4'(k);
      @(posedge clk);
      @(negedge clk);
    end
    valid_in = 1'b0;
    check("full_before_arst", outs(), {1'b0, 1'b0, 1'b1, 4'd11, 1'b1, 4'd12});
    #2;
    reset_L = 1'b0;
    #1;
    check("async_reset", outs(), {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0});
    @(negedge clk);
    reset_L  = 1'b1;
    valid_in = 1'b1;
    data_in  = 4'd9;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    check("first_after_arst", outs(), {1'b1, 1'b1, 1'b1, 4'd9, 1'b0, 4'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
